// File: rtl/sample_rate_crush.sv
// Decimating sample-and-hold for the crusher chain.
// Channel 0 is a CV that passes straight through and also sets the hold
// factor N. Channels 1-3 are captured on one tick out of every N and held
// in between. sample_clk is an asynchronous strobe. It is synchronised into
// clk, and the edge detector produces a registered one-clk tick.
module sample_rate_crush #(
  parameter int W           = 16,
  parameter int MAX_HOLD    = 16,
  parameter int CV_STEP     = 2000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3
);

  localparam int NW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {
    WAIT_FIRST = 1'b0,
    RUN        = 1'b1
  } state_t;

  // Synchroniser and edge detector.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   tick_q, tick_d;

  // Hold control.
  state_t        state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] hold_n_q, hold_n_d;
  logic [NW-1:0] n_cv;

  // Held audio.
  logic signed [W-1:0] out1_q, out1_d;
  logic signed [W-1:0] out2_q, out2_d;
  logic signed [W-1:0] out3_q, out3_d;

  // Shift sample_clk through the synchroniser and register a pulse on its rising edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sample_clk};
    prev_d = sync_q[SYNC_STAGES-1];
    tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Map the CV to N with a comparator chain: each threshold k*CV_STEP that is
  // reached raises N to k+1. Zero and negative CV pass no threshold, so they leave N = 1.
  always_comb begin
    int cv_int;
    cv_int = int'(sample_in0);
    n_cv   = NW'(1);
    for (int k = 1; k < MAX_HOLD; k++) begin
      if (cv_int >= k * CV_STEP) begin
        n_cv = NW'(k + 1);
      end
    end
  end

  // Hold FSM. A tick either captures and reloads the counter, or counts the hold down.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_n_d = hold_n_q;
    out1_d   = out1_q;
    out2_d   = out2_q;
    out3_d   = out3_q;
    if (tick_q) begin
      if (state_q == WAIT_FIRST || cnt_q == '0) begin
        out1_d   = sample_in1;
        out2_d   = sample_in2;
        out3_d   = sample_in3;
        hold_n_d = n_cv;
        cnt_d    = n_cv - NW'(1);
        state_d  = RUN;
      end else begin
        cnt_d = cnt_q - NW'(1);
      end
    end
  end

  // State registers. Reset takes priority over a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      tick_q   <= 1'b0;
      state_q  <= WAIT_FIRST;
      cnt_q    <= '0;
      hold_n_q <= NW'(1);
      out1_q   <= '0;
      out2_q   <= '0;
      out3_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      tick_q   <= tick_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_n_q <= hold_n_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      out3_q   <= out3_d;
    end
  end

  assign sample_out0 = sample_in0;
  assign sample_out1 = out1_q;
  assign sample_out2 = out2_q;
  assign sample_out3 = out3_q;

endmodule

// File: tb/tb_sample_rate_crush.sv
// Directed bench for sample_rate_crush.
// Each sample_clk period carries one stimulus vector, and the expected held
// triple for that period is queued. A monitor follows each sample_clk rise.
// Three clk edges later the outputs must still hold the previous value.
// Four clk edges later they must equal the queued value.
module tb_sample_rate_crush;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                sample_clk = 1'b0;
  logic signed [W-1:0] sample_in0 = '0;
  logic signed [W-1:0] sample_in1 = '0;
  logic signed [W-1:0] sample_in2 = '0;
  logic signed [W-1:0] sample_in3 = '0;
  logic signed [W-1:0] sample_out0;
  logic signed [W-1:0] sample_out1;
  logic signed [W-1:0] sample_out2;
  logic signed [W-1:0] sample_out3;

  logic [3*W-1:0] exp_q[$];
  logic [3*W-1:0] last_exp = '0;
  logic [W-1:0]   cur_cv = '0;
  int             checks = 0;
  int             failures = 0;

  sample_rate_crush dut (
    .clk         (clk),
    .rst         (rst),
    .sample_clk  (sample_clk),
    .sample_in0  (sample_in0),
    .sample_in1  (sample_in1),
    .sample_in2  (sample_in2),
    .sample_in3  (sample_in3),
    .sample_out0 (sample_out0),
    .sample_out1 (sample_out1),
    .sample_out2 (sample_out2),
    .sample_out3 (sample_out3)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got unfinished run, required completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Channel values derived from one vector value a: in1 = a, in2 = a+1000, in3 = -a-1.
  function automatic logic [3*W-1:0] pack(input int v);
    pack = {W'(v), W'(v + 1000), W'(-v - 1)};
  endfunction

  task automatic check3(input string name, input logic [3*W-1:0] e);
    checks++;
    if ({sample_out1, sample_out2, sample_out3} !== e) begin
      failures++;
      $display("FAIL %s: got out1=%0d out2=%0d out3=%0d, required %0d %0d %0d", name,
               sample_out1, sample_out2, sample_out3,
               $signed(e[3*W-1:2*W]), $signed(e[2*W-1:W]), $signed(e[W-1:0]));
    end
  endtask

  task automatic check_out0(input string name);
    checks++;
    if (sample_out0 !== cur_cv) begin
      failures++;
      $display("FAIL %s: got out0=%0d, required %0d", name, sample_out0, $signed(cur_cv));
    end
  endtask

  // Driver: one full sample_clk period (256 clk, 50% duty) for a single vector.
  task automatic run_vec(input int cv, input int a, input int e);
    @(negedge clk);
    cur_cv     = W'(cv);
    sample_in0 = W'(cv);
    sample_in1 = W'(a);
    sample_in2 = W'(a + 1000);
    sample_in3 = W'(-a - 1);
    exp_q.push_back(pack(e));
    sample_clk = 1'b1;
    repeat (128) @(negedge clk);
    sample_clk = 1'b0;
    repeat (127) @(negedge clk);
  endtask

  // Monitor: after each sample_clk rise, check the outputs on both sides of the capture edge.
  initial begin
    logic [3*W-1:0] e;
    forever begin
      @(posedge sample_clk);
      repeat (3) @(posedge clk);
      #1;
      check3("pre_capture_hold", last_exp);
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL queue_underflow: got empty queue, required an expected entry");
      end else begin
        e = exp_q.pop_front();
        check3("capture", e);
        last_exp = e;
      end
      check_out0("passthrough");
    end
  end

  int n4_exp[12] = '{1, 1, 1, 1, 5, 5, 5, 5, 9, 9, 9, 9};
  int cvc_exp[8] = '{1, 1, 1, 1, 5, 6, 7, 8};
  int sat_cv[8]  = '{-5000, -5000, 1999, 1999, 2000, 2000, 2000, 2000};
  int sat_exp[8] = '{17, 18, 19, 20, 21, 21, 23, 23};

  // Stimulus sequence.
  initial begin
    // Reset, with non-zero inputs and a negative CV present.
    cur_cv     = W'(-77);
    sample_in0 = W'(-77);
    sample_in1 = W'(1234);
    sample_in2 = W'(1234);
    sample_in3 = W'(1234);
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check3("reset_outputs", '0);
      check_out0("reset_passthrough");
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check3("no_capture_before_tick", '0);
    check_out0("post_reset_passthrough");

    // N = 1: every tick captures.
    run_vec(0, 100, 100);
    run_vec(0, 200, 200);
    run_vec(0, 300, 300);

    // N = 4.
    for (int i = 0; i < 12; i++) run_vec(6000, i + 1, n4_exp[i]);

    // CV drops to 0 mid-hold; the current hold of 4 completes first.
    for (int i = 0; i < 8; i++) run_vec((i < 2) ? 6000 : 0, i + 1, cvc_exp[i]);

    // Full-scale CV saturates at a hold of 16 ticks.
    for (int i = 0; i < 16; i++) run_vec(32767, i + 1, 1);
    // Negative CV, and the 1999/2000 threshold.
    for (int i = 0; i < 8; i++) run_vec(sat_cv[i], 17 + i, sat_exp[i]);

    // Reset mid-hold, with N = 4 and cnt = 2.
    run_vec(6000, 31, 31);
    run_vec(6000, 32, 31);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check3("reset_mid_hold", '0);
    rst = 1'b0;
    last_exp = '0;
    run_vec(6000, 41, 41);
    run_vec(6000, 42, 41);

    // Reset coincident with the tick cycle: that tick must not capture.
    // sample_clk is still high at release, so one fresh tick follows.
    @(negedge clk);
    cur_cv     = W'(0);
    sample_in0 = W'(0);
    sample_in1 = W'(50);
    sample_in2 = W'(1050);
    sample_in3 = W'(-51);
    exp_q.push_back('0);
    sample_clk = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check3("tick_after_rst_release", pack(50));
    last_exp = pack(50);
    repeat (118) @(negedge clk);
    sample_clk = 1'b0;
    repeat (127) @(negedge clk);

    run_vec(0, 60, 60);

    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
